// File: rtl/seed_lfsr_gen.sv
// Seed word producer: 64-bit-capable Galois LFSR behind a valid/ready handshake.
// Define SEED_LFSR_STEP4_EN to advance the LFSR four steps per transfer.
module seed_lfsr_gen #(
  parameter int          WIDTH = 64,
  parameter logic [63:0] TAPS  = 64'hD800_0000_0000_0000,
  parameter logic [63:0] INIT  = 64'h0000_0000_0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic [15:0]      burst_len,
  input  logic             stop,
  output logic [WIDTH-1:0] seed,
  output logic             seed_valid,
  input  logic             seed_ready,
  output logic             busy,
  output logic             done,
  output logic             lockup,
  output logic [15:0]      xfer_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_SEED = INIT[WIDTH-1:0];

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [15:0]      remaining;
  logic [15:0]      remaining_next;
  logic             done_next;
  logic             lockup_next;
  logic             xfer;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {1'b0, s[WIDTH-1:1]} ^ (s[0] ? TAP_MASK : {WIDTH{1'b0}});
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
`ifdef SEED_LFSR_STEP4_EN
    return lfsr_step(lfsr_step(lfsr_step(lfsr_step(s))));
`else
    return lfsr_step(s);
`endif
  endfunction

  assign seed       = lfsr;
  assign seed_valid = (state == RUN);
  assign busy       = (state == RUN);
  assign xfer       = (state == RUN) && seed_ready;

  // Next-state, LFSR, burst bookkeeping and lock-up decisions.
  always_comb begin
    state_next     = state;
    lfsr_next      = lfsr;
    remaining_next = remaining;
    done_next      = 1'b0;
    lockup_next    = lockup;
    case (state)
      IDLE: begin
        if (load) begin
          if (load_value == {WIDTH{1'b0}}) begin
            lfsr_next   = INIT_SEED;
            lockup_next = 1'b1;
          end else begin
            lfsr_next   = load_value;
            lockup_next = 1'b0;
          end
        end else if (start) begin
          remaining_next = burst_len;
          state_next     = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (xfer) begin
          lfsr_next = lfsr_advance(lfsr);
          if (remaining != 16'd0) begin
            remaining_next = remaining - 16'd1;
          end else begin
            remaining_next = remaining;
          end
        end else begin
          lfsr_next = lfsr;
        end
        // remaining stays 0 throughout free-run, so only a real burst can finish here.
        if (xfer && (remaining == 16'd1)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (stop) begin
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, LFSR and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= INIT_SEED;
      remaining  <= 16'd0;
      done       <= 1'b0;
      lockup     <= 1'b0;
      xfer_count <= 16'd0;
    end else begin
      state     <= state_next;
      lfsr      <= lfsr_next;
      remaining <= remaining_next;
      done      <= done_next;
      lockup    <= lockup_next;
      if (xfer) begin
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seed_lfsr_gen.sv
// Directed self-checking bench for seed_lfsr_gen (honours SEED_LFSR_STEP4_EN).
module tb_seed_lfsr_gen;

  localparam logic [63:0] TAPS_M = 64'hD800_0000_0000_0000;
`ifdef SEED_LFSR_STEP4_EN
  localparam logic [63:0] FIRST_NEXT  = 64'h1B00_0000_0000_0000;
  localparam logic [63:0] SECOND_NEXT = 64'h01B0_0000_0000_0000;
`else
  localparam logic [63:0] FIRST_NEXT  = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SECOND_NEXT = 64'h6C00_0000_0000_0000;
`endif

  logic        clk;
  logic        reset;
  logic        load;
  logic [63:0] load_value;
  logic        start;
  logic [15:0] burst_len;
  logic        stop;
  logic [63:0] seed;
  logic        seed_valid;
  logic        seed_ready;
  logic        busy;
  logic        done;
  logic        lockup;
  logic [15:0] xfer_count;

  int          n_cmp;
  int          n_err;
  logic [63:0] exp_seed;
  logic [15:0] exp_cnt;

  seed_lfsr_gen dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .burst_len  (burst_len),
    .stop       (stop),
    .seed       (seed),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .busy       (busy),
    .done       (done),
    .lockup     (lockup),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] m_step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? TAPS_M : 64'h0);
  endfunction

  function automatic logic [63:0] m_adv(input logic [63:0] s);
`ifdef SEED_LFSR_STEP4_EN
    return m_step(m_step(m_step(m_step(s))));
`else
    return m_step(s);
`endif
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    load = 1'b0;
    load_value = 64'h0;
    start = 1'b0;
    burst_len = 16'd0;
    stop = 1'b0;
    seed_ready = 1'b0;
    #2;
    check("rst_seed", seed, 64'h1);
    check("rst_valid", {63'h0, seed_valid}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_lockup", {63'h0, lockup}, 64'h0);
    check("rst_count", {48'h0, xfer_count}, 64'h0);
    tick();
    reset = 1'b0;

    // Burst of two with ready held high.
    seed_ready = 1'b1;
    burst_len = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2_valid0", {63'h0, seed_valid}, 64'h1);
    check("b2_busy0", {63'h0, busy}, 64'h1);
    check("b2_seed0", seed, 64'h1);
    tick();
    check("b2_seed1", seed, FIRST_NEXT);
    check("b2_cnt1", {48'h0, xfer_count}, 64'h1);
    check("b2_done_early", {63'h0, done}, 64'h0);
    tick();
    check("b2_done", {63'h0, done}, 64'h1);
    check("b2_busy_end", {63'h0, busy}, 64'h0);
    check("b2_valid_end", {63'h0, seed_valid}, 64'h0);
    check("b2_cnt2", {48'h0, xfer_count}, 64'h2);
    check("b2_lfsr", seed, SECOND_NEXT);
    tick();
    check("b2_done_off", {63'h0, done}, 64'h0);

    // Burst of three with a five-cycle stall after the first transfer.
    exp_seed = seed;
    exp_cnt = xfer_count;
    burst_len = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bp_seed0", seed, exp_seed);
    tick();
    seed_ready = 1'b0;
    exp_seed = m_adv(exp_seed);
    exp_cnt = exp_cnt + 16'd1;
    check("bp_seed1", seed, exp_seed);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stall_seed", seed, exp_seed);
      check("bp_stall_valid", {63'h0, seed_valid}, 64'h1);
      check("bp_stall_cnt", {48'h0, xfer_count}, {48'h0, exp_cnt});
    end
    seed_ready = 1'b1;
    tick();
    exp_seed = m_adv(exp_seed);
    exp_cnt = exp_cnt + 16'd1;
    check("bp_seed2", seed, exp_seed);
    check("bp_busy2", {63'h0, busy}, 64'h1);
    tick();
    exp_seed = m_adv(exp_seed);
    exp_cnt = exp_cnt + 16'd1;
    check("bp_seed3", seed, exp_seed);
    check("bp_cnt", {48'h0, xfer_count}, {48'h0, exp_cnt});
    check("bp_done", {63'h0, done}, 64'h1);
    check("bp_idle", {63'h0, busy}, 64'h0);
    tick();
    check("bp_done_off", {63'h0, done}, 64'h0);

    // Load handling: zero lock-up, normal load, load beats start, load ignored in RUN.
    load = 1'b1;
    load_value = 64'h0;
    tick();
    load = 1'b0;
    check("ld0_seed", seed, 64'h1);
    check("ld0_lockup", {63'h0, lockup}, 64'h1);
    load = 1'b1;
    load_value = 64'h0000_0000_DEAD_BEEF;
    tick();
    load = 1'b0;
    check("ld_seed", seed, 64'h0000_0000_DEAD_BEEF);
    check("ld_lockup", {63'h0, lockup}, 64'h0);
    load = 1'b1;
    load_value = 64'h0000_0000_0000_1234;
    start = 1'b1;
    burst_len = 16'd1;
    tick();
    load = 1'b0;
    start = 1'b0;
    check("ldst_busy", {63'h0, busy}, 64'h0);
    check("ldst_seed", seed, 64'h0000_0000_0000_1234);
    seed_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", {63'h0, busy}, 64'h1);
    load = 1'b1;
    load_value = 64'h5;
    tick();
    load = 1'b0;
    check("run_ld_seed", seed, 64'h0000_0000_0000_1234);
    check("run_ld_busy", {63'h0, busy}, 64'h1);
    seed_ready = 1'b1;
    exp_cnt = xfer_count;
    tick();
    check("b1_seed", seed, m_adv(64'h0000_0000_0000_1234));
    check("b1_done", {63'h0, done}, 64'h1);
    check("b1_idle", {63'h0, busy}, 64'h0);
    check("b1_cnt", {48'h0, xfer_count}, {48'h0, exp_cnt + 16'd1});
    tick();
    check("b1_done_off", {63'h0, done}, 64'h0);

    // Free-run: ten transfers, stop coincides with the tenth.
    exp_seed = seed;
    exp_cnt = xfer_count;
    burst_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fr_busy", {63'h0, busy}, 64'h1);
    check("fr_seed0", seed, exp_seed);
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_seed = m_adv(exp_seed);
      exp_cnt = exp_cnt + 16'd1;
      check("fr_seed", seed, exp_seed);
      check("fr_done", {63'h0, done}, 64'h0);
      check("fr_busy_run", {63'h0, busy}, 64'h1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_seed = m_adv(exp_seed);
    exp_cnt = exp_cnt + 16'd1;
    check("fr_stop_busy", {63'h0, busy}, 64'h0);
    check("fr_stop_valid", {63'h0, seed_valid}, 64'h0);
    check("fr_stop_done", {63'h0, done}, 64'h0);
    check("fr_stop_cnt", {48'h0, xfer_count}, {48'h0, exp_cnt});
    check("fr_stop_seed", seed, exp_seed);
    tick();
    check("fr_after_done", {63'h0, done}, 64'h0);
    check("fr_after_seed", seed, exp_seed);

    // Asynchronous reset between edges in the middle of a burst.
    burst_len = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ar_pre_busy", {63'h0, busy}, 64'h1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("ar_valid", {63'h0, seed_valid}, 64'h0);
    check("ar_busy", {63'h0, busy}, 64'h0);
    check("ar_seed", seed, 64'h1);
    check("ar_cnt", {48'h0, xfer_count}, 64'h0);
    #2;
    reset = 1'b0;
    tick();
    check("ar_after_busy", {63'h0, busy}, 64'h0);
    check("ar_after_seed", seed, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
